// File: rtl/branch_unit.sv
// branch_unit: RV32I branch resolver with a 2-bit counter BHT, registered mispredict redirect and saturating stats
module branch_unit #(
  parameter int XLEN = 32,
  parameter int BHT_ENTRIES = 64,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            ex_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [1:0] bht [BHT_ENTRIES];
  logic [IW-1:0] eidx;
  logic [1:0] cur;
  logic eq, slt, ult, cond, accept, mispredict;
  logic unused;
  assign unused = ^{pred_pc[XLEN-1:IW+2], pred_pc[1:0]};
  assign pred_taken = bht[pred_pc[IW+1:2]][1];
  // resolve the branch condition and decide whether this EX slot is accepted
  always_comb begin
    eidx = ex_pc[IW+1:2];
    cur = bht[eidx];
    eq = ex_rs1 == ex_rs2;
    slt = $signed(ex_rs1) < $signed(ex_rs2);
    ult = ex_rs1 < ex_rs2;
    cond = (ex_funct3[2] ? (ex_funct3[1] ? ult : slt) : eq) ^ ex_funct3[0];
    accept = ex_valid & ex_branch & (ex_funct3[2:1] != 2'b01) & ~redirect_valid;
    ex_taken = accept & cond;
    mispredict = accept & (ex_taken != ex_pred_taken);
  end
  // train the table, register the redirect and bump saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= INIT_STATE;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      stat_branches <= '0;
      stat_mispredicts <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= ex_taken ? ex_target : ex_pc + XLEN'(4);
      if (accept) bht[eidx] <= ex_taken ? (&cur ? cur : cur + 2'b01) : (~|cur ? cur : cur - 2'b01);
      if (accept && !(&stat_branches)) stat_branches <= stat_branches + CNT_W'(1);
      if (mispredict && !(&stat_mispredicts)) stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end
endmodule
